// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES-CTR core arbiter.
//   BLOCK_SIZE  : stream data width (bits), from `AES_BLOCK_SIZE when defined.
//   KEEP_W      : tkeep width (one bit per data byte).
//   HDR_BEATS   : header beats (key-low, key-high, counter) before the text.
//   arb_state_t : one-hot arbiter state encoding.
//   rr_pick     : round-robin winner selection between the two clients.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

package aes_pkg;

  localparam int BLOCK_SIZE = `AES_BLOCK_SIZE;
  localparam int KEEP_W     = BLOCK_SIZE / 8;

  localparam logic [1:0] HDR_BEATS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_FEED  = 3'b010,
    ST_DRAIN = 3'b100
  } arb_state_t;

  // A lone requester always wins; on a tie the client that was not granted
  // last time wins. With nobody valid the previous grantee is kept.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
    logic win;
    case (valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = last_grant;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/aes_ctr_arbiter.sv
// aes_ctr_arbiter: message-granular round-robin arbiter sharing one AES-256
// CTR core between two AXI-Stream clients.
//
// Ports
//   Clk, Rst              : clock; synchronous active-high reset.
//   S0_axis_*, S1_axis_*  : client request streams (key-lo, key-hi, counter,
//                           then text beats ending in tlast).
//   M0_axis_*, M1_axis_*  : client response streams.
//   C_s_axis_*            : stream into the core's slave port.
//   C_m_axis_*            : stream from the core's master port.
//   Busy                  : a message is in flight (state != ST_IDLE).
//   Owner                 : current or most recent grantee.
//
// Handshake: every stream moves a beat on a cycle where tvalid and tready are
// both high; tvalid never depends on tready on any path through this block,
// and all data paths are combinational (no storage, no added latency).
module aes_ctr_arbiter
  import aes_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,

  input  logic                  S0_axis_tvalid,
  output logic                  S0_axis_tready,
  input  logic [BLOCK_SIZE-1:0] S0_axis_tdata,
  input  logic [KEEP_W-1:0]     S0_axis_tkeep,
  input  logic                  S0_axis_tlast,
  input  logic                  S0_axis_tuser,

  input  logic                  S1_axis_tvalid,
  output logic                  S1_axis_tready,
  input  logic [BLOCK_SIZE-1:0] S1_axis_tdata,
  input  logic [KEEP_W-1:0]     S1_axis_tkeep,
  input  logic                  S1_axis_tlast,
  input  logic                  S1_axis_tuser,

  output logic                  M0_axis_tvalid,
  input  logic                  M0_axis_tready,
  output logic [BLOCK_SIZE-1:0] M0_axis_tdata,
  output logic [KEEP_W-1:0]     M0_axis_tkeep,
  output logic                  M0_axis_tlast,

  output logic                  M1_axis_tvalid,
  input  logic                  M1_axis_tready,
  output logic [BLOCK_SIZE-1:0] M1_axis_tdata,
  output logic [KEEP_W-1:0]     M1_axis_tkeep,
  output logic                  M1_axis_tlast,

  output logic                  C_s_axis_tvalid,
  input  logic                  C_s_axis_tready,
  output logic [BLOCK_SIZE-1:0] C_s_axis_tdata,
  output logic [KEEP_W-1:0]     C_s_axis_tkeep,
  output logic                  C_s_axis_tlast,
  output logic                  C_s_axis_tuser,

  input  logic                  C_m_axis_tvalid,
  output logic                  C_m_axis_tready,
  input  logic [BLOCK_SIZE-1:0] C_m_axis_tdata,
  input  logic [KEEP_W-1:0]     C_m_axis_tkeep,
  input  logic                  C_m_axis_tlast,

  output logic                  Busy,
  output logic                  Owner
);

  arb_state_t state, state_next;
  logic       last_grant, last_grant_next;
  logic [1:0] hdr_cnt, hdr_cnt_next;
  logic [1:0] hdr_inc;
  logic       feeding;
  logic       cs_hs, cm_hs;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      hdr_cnt    <= 2'd0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      hdr_cnt    <= hdr_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Request path: the granted client is wired straight to the core in FEED.
  // ---------------------------------------------------------------------------
  assign feeding = (state == ST_FEED);

  always_comb begin
    if (last_grant) begin
      C_s_axis_tvalid = feeding & S1_axis_tvalid;
      C_s_axis_tdata  = S1_axis_tdata;
      C_s_axis_tkeep  = S1_axis_tkeep;
      C_s_axis_tlast  = S1_axis_tlast;
      C_s_axis_tuser  = S1_axis_tuser;
    end else begin
      C_s_axis_tvalid = feeding & S0_axis_tvalid;
      C_s_axis_tdata  = S0_axis_tdata;
      C_s_axis_tkeep  = S0_axis_tkeep;
      C_s_axis_tlast  = S0_axis_tlast;
      C_s_axis_tuser  = S0_axis_tuser;
    end
  end

  assign S0_axis_tready = feeding & ~last_grant & C_s_axis_tready;
  assign S1_axis_tready = feeding &  last_grant & C_s_axis_tready;

  // ---------------------------------------------------------------------------
  // Response path: the core output always follows Owner, in every state.
  // ---------------------------------------------------------------------------
  assign M0_axis_tvalid  = ~last_grant & C_m_axis_tvalid;
  assign M1_axis_tvalid  =  last_grant & C_m_axis_tvalid;
  assign M0_axis_tdata   = C_m_axis_tdata;
  assign M1_axis_tdata   = C_m_axis_tdata;
  assign M0_axis_tkeep   = C_m_axis_tkeep;
  assign M1_axis_tkeep   = C_m_axis_tkeep;
  assign M0_axis_tlast   = C_m_axis_tlast;
  assign M1_axis_tlast   = C_m_axis_tlast;
  assign C_m_axis_tready = last_grant ? M1_axis_tready : M0_axis_tready;

  assign cs_hs = C_s_axis_tvalid & C_s_axis_tready;
  assign cm_hs = C_m_axis_tvalid & C_m_axis_tready;

  // Header-beat count including the beat being accepted now. It reaches
  // HDR_BEATS on the counter beat, so tlast there closes a zero-text message,
  // while tlast on either key beat is just forwarded.
  assign hdr_inc = (hdr_cnt == HDR_BEATS) ? hdr_cnt : hdr_cnt + 2'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    hdr_cnt_next    = hdr_cnt;
    case (state)
      ST_IDLE: begin
        if (S0_axis_tvalid || S1_axis_tvalid) begin
          last_grant_next = rr_pick({S1_axis_tvalid, S0_axis_tvalid}, last_grant);
          hdr_cnt_next    = 2'd0;
          state_next      = ST_FEED;
        end
      end
      ST_FEED: begin
        if (cs_hs) begin
          hdr_cnt_next = hdr_inc;
          if (C_s_axis_tlast && (hdr_inc == HDR_BEATS)) begin
            // A zero-latency core may hand back its last beat in the same
            // cycle the last input beat is taken; there is nothing to drain.
            if (cm_hs && C_m_axis_tlast) state_next = ST_IDLE;
            else                         state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (cm_hs && C_m_axis_tlast) state_next = ST_IDLE;
      end
      default: begin
        state_next   = ST_IDLE;
        hdr_cnt_next = 2'd0;
      end
    endcase
  end

  assign Busy  = (state != ST_IDLE);
  assign Owner = last_grant;

endmodule

// File: doc/aes_ctr_arbiter.md
# aes_ctr_arbiter

Packet-granular two-requester arbiter that shares one AES-256 CTR pipeline core between two AXI-Stream clients. Each client sends complete messages of the form key-low beat, key-high beat, counter beat, then text beats ending in tlast. The arbiter grants the core to one client per message, in round-robin order, and routes the core's output stream back to that client. It sits between the two client stream ports and the core's slave/master stream ports, and holds the grant until the last output beat has been delivered.

## Interface
- BLOCK_SIZE, `AES_BLOCK_SIZE` (128): stream data width in bits.
- HDR_BEATS, 3: header beats (key-low, key-high, counter) that precede the text beats.
- Clk  in  1  clock for all logic.
- Rst  in  1  reset; synchronous, active-high.
- S0_axis_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/BLOCK_SIZE/BLOCK_SIZE/8/1/1  client 0 request stream.
- S1_axis_* : same as S0_axis_*, client 1.
- M0_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/BLOCK_SIZE/BLOCK_SIZE/8/1  client 0 response stream.
- M1_axis_* : same as M0_axis_*, client 1.
- C_s_axis_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  as S0  stream to the core's slave port.
- C_m_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  as M0  stream from the core's master port.
- Busy  out  1  a message is in flight (state ≠ ST_IDLE).
- Owner  out  1  current or most recent grantee.

## Operation
- **States (one-hot):**
  - ST_IDLE: no grant. All S*_tready = 0 and C_s_axis_tvalid = 0.
    - If any S*_tvalid is high, register the grant and go to ST_FEED.
  - ST_FEED: the granted client's S port is wired straight to C_s_axis: valid, data, keep, last and user forward; C_s_axis_tready returns to that client.
    - On a C_s handshake, hdr_cnt increments, saturating at HDR_BEATS.
    - On a C_s handshake with tlast and hdr_cnt == HDR_BEATS, go to ST_DRAIN.
    - tlast on a header beat is forwarded but does not end the message.
  - ST_DRAIN: the requester's S tready = 0 and C_s_axis_tvalid = 0.
    - On a C_m handshake with tlast, go to ST_IDLE.
- **Output routing.** In every state, C_m_axis drives the M port of Owner, and C_m_axis_tready = that port's tready. The non-owner M port has tvalid = 0.
- **Overlap.** Output beats flow during ST_FEED as well as ST_DRAIN.
- **Arbitration.** Round robin on the last grant.
  - If only one client is valid, that client wins.
  - If both are valid, the client that was not last granted wins.
  - last_grant resets to 1, so client 0 wins the first tie.
  - Owner = last_grant.
- **Non-owner.** The non-owner is never granted mid-message. Its tvalid may stay high indefinitely; its data is not consumed.
- **Boundaries:**
  - A message with zero text beats (tlast on the third beat) is legal; the core then produces one output beat.
  - Requester valid deasserting mid-message simply stalls the message.
  - Output backpressure stalls the core and therefore the feed; the arbiter inserts no buffering.
- **Reset mid-message.** The arbiter returns to ST_IDLE and hdr_cnt clears. The core shares Rst, so the partial message is discarded in both.

## Timing
- **Reset values:**
  - Busy = 0, Owner = 1.
  - All S*_tready = 0.
  - M*_tvalid = 0.
  - C_s_axis_tvalid = 0.
  - C_m_axis_tready reflects M1_axis_tready, because Owner = 1.
- **Grant latency.** With a client valid in ST_IDLE at cycle N, the grant is registered at edge N+1 and first-beat forwarding is possible in cycle N+1.
- **Datapath.** Zero-latency combinational pass-through on all stream paths; no registers on data.
- **Turnaround.** The C_m tlast handshake at cycle N gives ST_IDLE at N+1 and a new grant at N+2. Minimum dead time between messages is 1 cycle in ST_IDLE.
- **hdr_cnt.** 2-bit counter; clears on entry to ST_FEED.

## Structure
- **aes_pkg:**
  - State enum type.
  - HDR_BEATS constant.
  - rr_pick(valid[1:0], last_grant) function, returning the winner index.
- No sub-module. The core is instantiated beside the arbiter by the parent, not inside it.

## Test plan
- **Single client:** client 0 sends key beats, counter f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff and plaintext 6bc1bee22e409f96e93d7e117393172a -> M0 receives 601ec313775789a5b7a7f504bbf3d228 with tlast; M1 tvalid never asserts; Owner = 0.
- **Tie after reset:** both clients valid in the same cycle -> client 0 is served first, then client 1. Each M port receives only its own ciphertext. Busy drops for exactly 1 cycle between messages.
- **Fairness:** client 0 sends back-to-back 3-message bursts while client 1 holds valid continuously -> grant order is 0,1,0,1,...
- **Header tlast ignored:** tlast = 1 on the key-high beat, followed by a 4-beat text -> the arbiter stays in ST_FEED until the 4th text beat's tlast, and 4 output beats return.
- **Backpressure:** M0 tready toggles 1010...; client 1 valid mid-message -> client 1 gets S1 tready = 0 until the client 0 output tlast handshake. No beats are lost or duplicated.
- **Reset mid-message:** Rst asserted after 2 text beats -> the next cycle shows Busy = 0 and all valids = 0; a fresh message afterwards completes correctly.
